// File: rtl/add32_seq_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract controller.
package add32_seq_ctrl_pkg;

  // Controller states: waiting for a request, chaining bytes, presenting a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default operand width in bytes.
  localparam int unsigned NUM_BYTES_DEFAULT = 4;

endpackage : add32_seq_ctrl_pkg

// File: rtl/add32_seq_ctrl_adder.sv
// 8-bit ripple adder slice with carry-in, carry-out and signed-overflow flag.
module adder_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o,
  output logic       ovf_o
);

  logic [7:0] low_sum;
  logic [1:0] high_sum;

  // Split at bit 7 so the carry into the MSB is visible for the overflow flag.
  always_comb begin
    low_sum  = {1'b0, a_i[6:0]} + {1'b0, b_i[6:0]} + {7'd0, cin_i};
    high_sum = {1'b0, a_i[7]} + {1'b0, b_i[7]} + {1'b0, low_sum[7]};
    sum_o    = {high_sum[0], low_sum[6:0]};
    cout_o   = high_sum[1];
    ovf_o    = low_sum[7] ^ high_sum[1];
  end

endmodule : adder_8bit

// File: rtl/add32_seq_ctrl.sv
// Byte-serial W-bit add/subtract with valid/ready handshakes on both sides.
// One shared 8-bit adder processes one byte per cycle, LSB first.
module add32_seq_ctrl
  import add32_seq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BYTES = NUM_BYTES_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [8*NUM_BYTES-1:0] i_op_a,
  input  logic [8*NUM_BYTES-1:0] i_op_b,
  input  logic                   i_sub,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [8*NUM_BYTES-1:0] o_result,
  output logic                   o_carry,
  output logic                   o_ovf
);

  localparam int unsigned W     = 8 * NUM_BYTES;
  localparam int unsigned IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       a_byte, b_byte, add_sum;
  logic             add_co, add_ovf;
  logic [W-1:0]     acc_next;

  adder_8bit u_adder (
    .a_i    (a_byte),
    .b_i    (b_byte),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_co),
    .ovf_o  (add_ovf)
  );

  // Index-driven byte select of the latched operands, and merge of the new sum byte.
  always_comb begin
    a_byte   = '0;
    b_byte   = '0;
    acc_next = acc_q;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_byte              = a_q[i*8 +: 8];
        b_byte              = b_q[i*8 +: 8];
        acc_next[i*8 +: 8]  = add_sum;
      end
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_op_a;
          b_d     = i_sub ? ~i_op_b : i_op_b;
          carry_d = i_sub;
          idx_d   = '0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_next;
        carry_d = add_co;
        if (idx_q == LAST_IDX) begin
          result_d = acc_next;
          co_d     = add_co;
          ovf_d    = add_ovf;
          idx_d    = '0;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;
  assign o_carry  = co_q;
  assign o_ovf    = ovf_q;

endmodule : add32_seq_ctrl

// File: tb/tb_add32_seq_ctrl.sv
// Directed self-checking bench for add32_seq_ctrl (NUM_BYTES = 4).
module tb_add32_seq_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         valid_out;
  logic         ready_in;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [W-1:0] last_res;

  add32_seq_ctrl #(.NUM_BYTES(NB)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid_in),
    .o_ready  (ready_out),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .i_sub    (sub),
    .o_valid  (valid_out),
    .i_ready  (ready_in),
    .o_result (result),
    .o_carry  (carry),
    .o_ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with i_ready held high; checks latency and results.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] exp_r, input logic exp_c,
                       input logic exp_v);
    int unsigned cyc;
    cyc = 0;
    while (!ready_out && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_ready"}, 64'(ready_out), 64'd1);
    valid_in = 1'b1;
    op_a     = a;
    op_b     = b;
    sub      = s;
    ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    sub      = 1'b0;
    cyc      = 0;
    while (!valid_out && cyc < 20) begin
      chk({tag, "_hold"}, 64'(result), 64'(last_res));
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(NB));
    chk({tag, "_res"}, 64'(result), 64'(exp_r));
    chk({tag, "_c"},   64'(carry), 64'(exp_c));
    chk({tag, "_v"},   64'(ovf), 64'(exp_v));
    last_res = exp_r;
    tick();
    chk({tag, "_idle"}, 64'({valid_out, ready_out}), 64'b01);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } vec_t;

  vec_t b2b[4];

  initial begin
    int unsigned cyc;
    int unsigned k;
    int unsigned d;
    int unsigned prev_acc;
    bit          have_prev;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    op_a     = '0;
    op_b     = '0;
    sub      = 1'b0;
    last_res = '0;
    #12;
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_res",   64'(result), 64'd0);
    chk("rst_flags", 64'({carry, ovf}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    do_op("add_ff",   32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op("add_mix",  32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
    do_op("sub_zero", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // Backpressure: hold result under i_ready = 0 with a new request pending.
    valid_in = 1'b1;
    ready_in = 1'b0;
    op_a     = 32'h0000_0003;
    op_b     = 32'h0000_0004;
    sub      = 1'b0;
    tick();
    cyc = 0;
    while (!valid_out && cyc < 20) begin
      op_a = $urandom;
      op_b = $urandom;
      sub  = ~sub;
      tick();
      cyc++;
    end
    chk("bp_lat", 64'(cyc), 64'(NB));
    for (int i = 0; i < 3; i++) begin
      chk("bp_res",   64'(result), 64'h7);
      chk("bp_flags", 64'({carry, ovf}), 64'd0);
      chk("bp_hs",    64'({valid_out, ready_out}), 64'b10);
      op_a = $urandom;
      op_b = $urandom;
      sub  = ~sub;
      tick();
    end
    chk("bp_res_end", 64'(result), 64'h7);
    ready_in = 1'b1;
    tick();
    chk("bp_back_idle", 64'({valid_out, ready_out}), 64'b01);
    valid_in = 1'b0;
    last_res = 32'h7;
    tick();
    chk("bp_no_bypass", 64'(ready_out), 64'd1);

    // Reset during the second CALC cycle aborts the operation.
    valid_in = 1'b1;
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'hFFFF_FFFF;
    sub      = 1'b0;
    tick();
    valid_in = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_res",   64'(result), 64'd0);
    chk("abort_flags", 64'({carry, ovf}), 64'd0);
    chk("abort_hs",    64'({valid_out, ready_out}), 64'b01);
    tick();
    rst_n = 1'b1;
    last_res = '0;
    tick();
    chk("abort_ready", 64'(ready_out), 64'd1);
    do_op("post_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);

    // Back-to-back with i_valid and i_ready held high.
    b2b[0] = '{32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0};
    b2b[1] = '{32'h0000_0010, 32'h0000_0020, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0};
    b2b[2] = '{32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    b2b[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    ready_in  = 1'b1;
    valid_in  = 1'b1;
    k         = 0;
    d         = 0;
    prev_acc  = 0;
    have_prev = 1'b0;
    for (int unsigned c = 0; c < 60 && d < 4; c++) begin
      if (valid_out) begin
        chk("b2b_res", 64'(result), 64'(b2b[d].r));
        chk("b2b_cv",  64'({carry, ovf}), 64'({b2b[d].c, b2b[d].v}));
        d++;
      end
      if (ready_out && valid_in) begin
        op_a = b2b[k].a;
        op_b = b2b[k].b;
        sub  = b2b[k].s;
        if (have_prev) chk("b2b_gap", 64'(c - prev_acc), 64'(NB + 2));
        prev_acc  = c;
        have_prev = 1'b1;
        k++;
      end else begin
        op_a = $urandom;
        op_b = $urandom;
        sub  = ~sub;
      end
      tick();
      if (k == 4) valid_in = 1'b0;
    end
    chk("b2b_count", 64'(d), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_add32_seq_ctrl

// File: doc/add32_seq_ctrl.md
ADD32_SEQ_CTRL -- requirements
Module: add32_seq_ctrl

Interface
REQ-001 Parameter: NUM_BYTES, 4, operand width in bytes; result width is 8*NUM_BYTES (W); legal range 2..8.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  upstream request valid.
REQ-005 o_ready  output  1  block can accept a request.
REQ-006 i_op_a  input  W  operand A.
REQ-007 i_op_b  input  W  operand B.
REQ-008 i_sub  input  1  0 = A+B, 1 = A-B (two's complement).
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  downstream accepts result.
REQ-011 o_result  output  W  sum/difference.
REQ-012 o_carry  output  1  carry out of MSB byte (subtract: 1 = no borrow).
REQ-013 o_ovf  output  1  signed overflow of the full W-bit operation.

Function
REQ-014 The block SHALL compute the W-bit result using one shared 8-bit adder, one byte per cycle, LSB byte first, carry chained through a carry register.
REQ-015 FSM states SHALL be IDLE, CALC, DONE; o_ready = 1 only in IDLE; o_valid = 1 only in DONE.
REQ-016 Accept: i_valid & o_ready at a rising edge SHALL latch i_op_a, i_op_b (inverted when i_sub = 1), set carry register to i_sub, clear byte index, go to CALC.
REQ-017 CALC: each cycle the adder SHALL take byte[idx] of latched A and B plus carry register; at the edge, result byte[idx] and carry register update, idx increments.
REQ-018 When idx = NUM_BYTES-1 in CALC, the edge SHALL store the last byte, load o_carry from adder carry-out and o_ovf from adder overflow, and go to DONE.
REQ-019 Latency: o_valid SHALL assert exactly NUM_BYTES cycles after the accept edge; peak throughput one operation per NUM_BYTES+2 cycles.
REQ-020 DONE: o_result, o_carry, o_ovf SHALL be held stable while i_ready = 0; o_valid & i_ready at an edge SHALL return to IDLE.
REQ-021 i_valid, operand and i_sub changes outside IDLE SHALL be ignored; no request is accepted in the DONE->IDLE cycle (no bypass).
REQ-022 o_result, o_carry, o_ovf SHALL change only at the REQ-018 edge; intermediate bytes are held in an internal register, not driven to o_result early.
REQ-023 Arithmetic SHALL be modulo 2^W; o_ovf = carry-into-MSB XOR carry-out-of-MSB of the final byte.

Reset
REQ-024 i_rst_n low SHALL immediately force IDLE, idx = 0, carry register = 0, o_result = 0, o_carry = 0, o_ovf = 0, o_valid = 0, o_ready = 1 after release edge logic (o_ready is 1 combinationally from IDLE).
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation; no result is produced for it.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE, CALC, DONE) and the default NUM_BYTES constant.
REQ-027 The block SHALL instantiate exactly one adder_8bit as its datapath sub-module; no other adder logic in the controller.
REQ-028 Byte selection SHALL be an index-driven mux; idx width = clog2(NUM_BYTES).

Verification
REQ-029 ADD 0x000000FF + 0x00000001 -> o_result 0x00000100, carry 0, ovf 0, o_valid 4 cycles after accept.
REQ-030 ADD 0xFFFFFFFF + 0x00000001 -> 0x00000000, carry 1, ovf 0; ADD 0x7FFFFFFF + 1 -> 0x80000000, carry 0, ovf 1.
REQ-031 SUB 5 - 7 -> 0xFFFFFFFE, carry 0, ovf 0; SUB 0x80000000 - 1 -> 0x7FFFFFFF, carry 1, ovf 1.
REQ-032 Backpressure: i_ready = 0 for 3 cycles in DONE with i_valid held high and operands changing -> outputs stable, o_ready 0, then one handshake and return to IDLE.
REQ-033 Reset pulse at second CALC cycle -> all outputs zero, o_ready 1 after release, next request 1 + 2 -> 0x00000003 with no residue from aborted operation.
REQ-034 Back-to-back requests with i_valid constantly high and i_ready = 1 -> accepts spaced exactly 6 cycles apart, each result correct.
